// File: rtl/wb_mem_arbiter.sv
// Two-master, one-slave Wishbone B4 pipelined arbiter with round-robin grant,
// cyc-long ownership and a per-transfer ack watchdog.
module wb_mem_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   // M0: instruction fetch
   input  logic                m0_cyc,
   input  logic                m0_stb,
   input  logic                m0_we,
   input  logic [ADDR_W-1:0]   m0_adr,
   input  logic [DATA_W-1:0]   m0_dat_o,
   input  logic [DATA_W/8-1:0] m0_sel,
   output logic                m0_ack,
   output logic                m0_err,
   output logic                m0_stall,
   output logic [DATA_W-1:0]   m0_dat_i,
   // M1: load/store
   input  logic                m1_cyc,
   input  logic                m1_stb,
   input  logic                m1_we,
   input  logic [ADDR_W-1:0]   m1_adr,
   input  logic [DATA_W-1:0]   m1_dat_o,
   input  logic [DATA_W/8-1:0] m1_sel,
   output logic                m1_ack,
   output logic                m1_err,
   output logic                m1_stall,
   output logic [DATA_W-1:0]   m1_dat_i,
   // Slave
   output logic                s_cyc,
   output logic                s_stb,
   output logic                s_we,
   output logic [ADDR_W-1:0]   s_adr,
   output logic [DATA_W-1:0]   s_dat_o,
   output logic [DATA_W/8-1:0] s_sel,
   input  logic                s_ack,
   input  logic                s_err,
   input  logic                s_stall,
   input  logic [DATA_W-1:0]   s_dat_i
);

   // Counter is sized to hold TIMEOUT; a 1-bit dummy when the watchdog is disabled.
   localparam int unsigned    WdtW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WdtW-1:0] WdtLast = WdtW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StOwnM0 = 2'd1,
      StOwnM1 = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic            last_q, last_d;   // 0: M0 owned last, 1: M1 owned last
   logic [WdtW-1:0] wdt_q, wdt_d;
   logic            err_q, err_d;     // watchdog error pulse for the owner

   logic                owned, sel_m1;
   logic                own_cyc, own_stb, own_we;
   logic [ADDR_W-1:0]   own_adr;
   logic [DATA_W-1:0]   own_dat;
   logic [DATA_W/8-1:0] own_sel;
   logic                wdt_fire;

   // Read data is broadcast; only ack qualifies it.
   assign m0_dat_i = s_dat_i;
   assign m1_dat_i = s_dat_i;

   // Select the current owner's request signals.
   always_comb begin
      owned   = (state_q != StIdle);
      sel_m1  = (state_q == StOwnM1);
      own_cyc = sel_m1 ? m1_cyc   : m0_cyc;
      own_stb = sel_m1 ? m1_stb   : m0_stb;
      own_we  = sel_m1 ? m1_we    : m0_we;
      own_adr = sel_m1 ? m1_adr   : m0_adr;
      own_dat = sel_m1 ? m1_dat_o : m0_dat_o;
      own_sel = sel_m1 ? m1_sel   : m0_sel;
   end

   // Watchdog: count strobed cycles without a response; an ack in the last cycle wins.
   always_comb begin
      wdt_fire = 1'b0;
      wdt_d    = '0;
      if (TIMEOUT != 0 && owned && own_stb && !err_q && !s_ack && !s_err) begin
         if (wdt_q == WdtLast) begin
            wdt_fire = 1'b1;
         end
         wdt_d = wdt_q + 1'b1;
      end
      err_d = wdt_fire;
   end

   // Arbitration: round-robin on ties, ownership held until the owner drops cyc.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         StIdle: begin
            if (m0_cyc && m1_cyc) begin
               state_d = last_q ? StOwnM0 : StOwnM1;
               last_d  = ~last_q;
            end else if (m0_cyc) begin
               state_d = StOwnM0;
               last_d  = 1'b0;
            end else if (m1_cyc) begin
               state_d = StOwnM1;
               last_d  = 1'b1;
            end
         end
         StOwnM0, StOwnM1: begin
            if (!own_cyc) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Bus routing: owner gets the slave, everyone else sees stall.
   always_comb begin
      s_cyc    = 1'b0;
      s_stb    = 1'b0;
      s_we     = 1'b0;
      s_adr    = '0;
      s_dat_o  = '0;
      s_sel    = '0;
      m0_ack   = 1'b0;
      m0_err   = 1'b0;
      m0_stall = 1'b1;
      m1_ack   = 1'b0;
      m1_err   = 1'b0;
      m1_stall = 1'b1;
      if (owned) begin
         s_cyc   = own_cyc;
         s_stb   = own_stb & ~err_q;   // watchdog cycle withdraws the strobe
         s_we    = own_we;
         s_adr   = own_adr;
         s_dat_o = own_dat;
         s_sel   = own_sel;
         if (sel_m1) begin
            m1_ack   = s_ack;
            m1_err   = s_err | err_q;
            m1_stall = s_stall;
         end else begin
            m0_ack   = s_ack;
            m0_err   = s_err | err_q;
            m0_stall = s_stall;
         end
      end
   end

   // State, round-robin pointer and watchdog registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         last_q  <= 1'b0;
         wdt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         wdt_q   <= wdt_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: directed scenarios plus random traffic
// compared against a behavioural owner/timeout model.
module tb_wb_mem_arbiter;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        mcyc [2];
   logic        mstb [2];
   logic        mwe  [2];
   logic [31:0] madr [2];
   logic [31:0] mdo  [2];
   logic [3:0]  msel [2];
   logic        mack [2];
   logic        merr [2];
   logic        mstall [2];
   logic [31:0] mdi  [2];
   logic        s_cyc, s_stb, s_we;
   logic [31:0] s_adr, s_dat_o;
   logic [3:0]  s_sel;
   logic        s_ack, s_err, s_stall;
   logic [31:0] s_dat_i;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the bus, who owned it last, how long the
   // current strobe has waited, and whether a timeout error is due now.
   int owner;
   int last_owner;
   int waited;
   bit timeout_due;

   // Values seen at the most recent sample point.
   logic        obs_err0, obs_ack0, obs_stb;
   logic [31:0] obs_adr;

   always #5 clk = ~clk;

   wb_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk      (clk),
      .rst      (rst),
      .m0_cyc   (mcyc[0]),
      .m0_stb   (mstb[0]),
      .m0_we    (mwe[0]),
      .m0_adr   (madr[0]),
      .m0_dat_o (mdo[0]),
      .m0_sel   (msel[0]),
      .m0_ack   (mack[0]),
      .m0_err   (merr[0]),
      .m0_stall (mstall[0]),
      .m0_dat_i (mdi[0]),
      .m1_cyc   (mcyc[1]),
      .m1_stb   (mstb[1]),
      .m1_we    (mwe[1]),
      .m1_adr   (madr[1]),
      .m1_dat_o (mdo[1]),
      .m1_sel   (msel[1]),
      .m1_ack   (mack[1]),
      .m1_err   (merr[1]),
      .m1_stall (mstall[1]),
      .m1_dat_i (mdi[1]),
      .s_cyc    (s_cyc),
      .s_stb    (s_stb),
      .s_we     (s_we),
      .s_adr    (s_adr),
      .s_dat_o  (s_dat_o),
      .s_sel    (s_sel),
      .s_ack    (s_ack),
      .s_err    (s_err),
      .s_stall  (s_stall),
      .s_dat_i  (s_dat_i)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      owner       = -1;
      last_owner  = 0;
      waited      = 0;
      timeout_due = 1'b0;
   endtask

   // Compare every DUT output with what the model says the bus should show now.
   task automatic check_all();
      logic        e_cyc, e_stb, e_we;
      logic [31:0] e_adr, e_dat;
      logic [3:0]  e_sel;
      e_cyc = 0; e_stb = 0; e_we = 0; e_adr = 0; e_dat = 0; e_sel = 0;
      if (owner >= 0) begin
         e_cyc = mcyc[owner];
         e_stb = mstb[owner] && !timeout_due;
         e_we  = mwe[owner];
         e_adr = madr[owner];
         e_dat = mdo[owner];
         e_sel = msel[owner];
      end
      chk("s_cyc", 64'(s_cyc), 64'(e_cyc));
      chk("s_stb", 64'(s_stb), 64'(e_stb));
      chk("s_we", 64'(s_we), 64'(e_we));
      chk("s_adr", 64'(s_adr), 64'(e_adr));
      chk("s_dat_o", 64'(s_dat_o), 64'(e_dat));
      chk("s_sel", 64'(s_sel), 64'(e_sel));
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("m%0d_ack", i), 64'(mack[i]), 64'((owner == i) && s_ack));
         chk($sformatf("m%0d_err", i), 64'(merr[i]),
             64'((owner == i) && (s_err || timeout_due)));
         chk($sformatf("m%0d_stall", i), 64'(mstall[i]), 64'((owner == i) ? s_stall : 1'b1));
         chk($sformatf("m%0d_dat_i", i), 64'(mdi[i]), 64'(s_dat_i));
      end
      obs_err0 = merr[0];
      obs_ack0 = mack[0];
      obs_stb  = s_stb;
      obs_adr  = s_adr;
   endtask

   // Advance the model across one rising edge using the inputs present at it.
   task automatic model_update();
      if (rst) begin
         model_reset();
      end else if (owner < 0) begin
         waited      = 0;
         timeout_due = 1'b0;
         if (mcyc[0] && mcyc[1]) owner = 1 - last_owner;
         else if (mcyc[0])       owner = 0;
         else if (mcyc[1])       owner = 1;
         if (owner >= 0) last_owner = owner;
      end else begin
         bit stuck;
         stuck       = mstb[owner] && !timeout_due && !s_ack && !s_err;
         timeout_due = stuck && (waited == TO - 1);
         waited      = stuck ? waited + 1 : 0;
         if (!mcyc[owner]) owner = -1;
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_master(input int i, input logic cyc, input logic [31:0] adr);
      mcyc[i] = cyc;
      mstb[i] = cyc;
      mwe[i]  = 1'b0;
      madr[i] = adr;
      mdo[i]  = 32'h0;
      msel[i] = 4'hF;
   endtask

   task automatic rand_inputs(input int ack_pct, input bit hold_stb);
      for (int i = 0; i < 2; i++) begin
         if ($urandom_range(0, 7) == 0) mcyc[i] = !mcyc[i];
         mstb[i] = mcyc[i] && (hold_stb || $urandom_range(0, 3) != 0);
         mwe[i]  = 1'($urandom);
         madr[i] = $urandom;
         mdo[i]  = $urandom;
         msel[i] = 4'($urandom);
      end
      s_ack   = ($urandom_range(0, 99) < ack_pct);
      s_err   = !hold_stb && ($urandom_range(0, 31) == 0);
      s_stall = ($urandom_range(0, 3) == 0);
      s_dat_i = $urandom;
   endtask

   initial begin
      int first_err;
      int err_seen;
      rst = 1'b1;
      set_master(0, 1'b0, 32'h0);
      set_master(1, 1'b0, 32'h0);
      s_ack = 0; s_err = 0; s_stall = 0; s_dat_i = 32'h0;
      model_reset();

      // Reset values, including a spurious ack while idle.
      step();
      s_ack = 1'b1;
      step();
      s_ack = 1'b0;
      rst   = 1'b0;
      step();

      // Contention after reset: M1 first, then M0 two cycles after M1 releases.
      set_master(0, 1'b1, 32'h1000);
      set_master(1, 1'b1, 32'h2000);
      step();
      chk("tie_idle_adr", 64'(obs_adr), 64'h0);
      step();
      chk("tie_grant_m1", 64'(obs_adr), 64'h2000);
      set_master(1, 1'b0, 32'h2000);
      step();
      step();
      chk("release_bubble", 64'(obs_adr), 64'h0);
      step();
      chk("grant_m0_after", 64'(obs_adr), 64'h1000);
      set_master(0, 1'b0, 32'h0);
      step();
      step();

      // Watchdog: M0 strobes, slave never answers.
      set_master(0, 1'b1, 32'h300);
      first_err = -1;
      for (int i = 0; i < 14; i++) begin
         step();
         if (obs_err0 && first_err < 0) begin
            first_err = i;
            chk("timeout_stb_low", 64'(obs_stb), 64'h0);
         end
      end
      chk("timeout_cycle", 64'(first_err), 64'(TO + 1));
      set_master(0, 1'b0, 32'h0);
      step();
      step();

      // Ack on the expiry cycle wins over the watchdog.
      set_master(0, 1'b1, 32'h400);
      err_seen = 0;
      for (int i = 0; i < 13; i++) begin
         s_ack = (i == TO);
         step();
         if (obs_err0) err_seen++;
         if (i == TO) chk("late_ack_passed", 64'(obs_ack0), 64'h1);
      end
      chk("late_ack_no_err", 64'(err_seen), 64'h0);
      s_ack = 1'b0;
      set_master(0, 1'b0, 32'h0);
      step();
      step();

      // Asynchronous reset between edges during an M1 transfer.
      set_master(1, 1'b1, 32'h500);
      step();
      step();
      @(negedge clk);
      #2;
      rst   = 1'b1;
      s_ack = 1'b1;
      #1;
      chk("arst_s_cyc", 64'(s_cyc), 64'h0);
      chk("arst_s_stb", 64'(s_stb), 64'h0);
      chk("arst_m1_ack", 64'(mack[1]), 64'h0);
      chk("arst_m1_stall", 64'(mstall[1]), 64'h1);
      chk("arst_m0_stall", 64'(mstall[0]), 64'h1);
      model_reset();
      @(posedge clk);
      #1;
      s_ack = 1'b0;
      set_master(1, 1'b0, 32'h0);
      step();
      rst = 1'b0;
      set_master(0, 1'b1, 32'h600);
      step();
      step();
      chk("post_rst_grant", 64'(obs_adr), 64'h600);
      set_master(0, 1'b0, 32'h0);
      step();
      step();

      // Random traffic: responsive slave, then a mostly silent one to hit timeouts.
      for (int n = 0; n < 400; n++) begin
         rand_inputs(50, 1'b0);
         step();
      end
      for (int n = 0; n < 400; n++) begin
         rand_inputs(3, 1'b1);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
